apb_north_arbiter: RTL and testbench
====================================

// Module: apb_north_arbiter
// PURPOSE
//  Shares the north APB slave port of the 16-stage APB write pipeline among NUM_MASTERS APB
//  write masters. Round-robin grant; each grant runs one SETUP+ACCESS transfer on north.
//  Tracks in-flight transfers so that pipeline_busy signals when south has yet to emit them.
//  Sits between the masters (agents/DUT sources) and the pipeline's north_* inputs.
// PARAMETERS
//  NUM_MASTERS   4    number of requesting APB masters (2..8)
//  DATA_WIDTH    32   pwdata width; matches pipeline
//  PIPE_LATENCY  16   cycles from north ACCESS (psel&&penable) to south ACCESS
// PORTS
//  clk            in   1                  clock; all logic on posedge
//  reset_n        in   1                  synchronous reset, active-low
//  m_psel         in   NUM_MASTERS        per-master psel
//  m_penable      in   NUM_MASTERS        per-master penable
//  m_pwdata       in   NUM_MASTERS*DW     per-master pwdata; master i in [i*DW +: DW]
//  m_pready       out  NUM_MASTERS        per-master pready, one-hot or zero
//  north_psel     out  1                  to pipeline north_psel
//  north_penable  out  1                  to pipeline north_penable
//  north_pwdata   out  DATA_WIDTH         to pipeline north_pwdata
//  grant_id       out  $clog2(NUM_MASTERS) index of master owning north (valid when north_psel)
//  pipeline_busy  out  1                  1 while any completed north transfer not yet at south
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, rr last-grant ptr=NUM_MASTERS-1, data reg=0,
//   in-flight shift reg=0. All outputs 0 in the cycle after the reset edge. A reset mid-transfer
//   aborts it: no pready to the master, in-flight history cleared, pipeline_busy drops.
//  FSM (registered state):
//   IDLE:   if any m_psel -> pick winner, latch its id and m_pwdata, go SETUP. Else stay.
//   SETUP:  north_psel=1, north_penable=0, north_pwdata=latched data. Always -> ACCESS.
//   ACCESS: north_psel=1. north_penable = m_penable[grant]. m_pready[grant] = m_penable[grant].
//           While m_penable[grant]=0: wait cycle; north stays psel=1, penable=0. No shift.
//           On m_penable[grant]=1: transfer completes this cycle. Next state SETUP when another
//           master (not grant) has psel=1, with new winner latched. Otherwise IDLE.
//  Arbitration: round-robin; search starts at (last_grant+1) mod N, so master 0 is first after
//   reset. Pointer updates only on grant. In ACCESS the current grant is excluded; it can
//   re-win only from IDLE. A single master doing back-to-back writes gets 3 cycles per transfer.
//   Other masters get 2 cycles back-to-back.
//  Data: pwdata sampled once at grant; later master changes are ignored for that transfer.
//  Master dropping psel while granted: transfer still completes on north. pready is not issued
//   until m_penable[grant]=1. A master that never raises penable stalls north (by design; the
//   checker flags it).
//  north_pwdata holds the last latched value in IDLE. north_psel/penable are 0 in IDLE.
//  m_pready: exactly one completion pulse per grant. Never asserted outside ACCESS.
//  In-flight: PIPE_LATENCY-bit shift reg, bit0 <= north_psel&&north_penable.
//   pipeline_busy = |shreg. After the last completion it stays 1 for exactly PIPE_LATENCY
//   cycles, then drops, aligned with the final south ACCESS cycle.
// STRUCTURE
//  apb_pipeline_pkg: arb_state_e {IDLE,SETUP,ACCESS}; PIPE_LATENCY default constant.
//  Sub-module rr_arbiter #(N): combinational req/mask/last_ptr -> one-hot grant + index.
//  The FSM, data latch and in-flight tracker stay in apb_north_arbiter.
// TESTING
//  1 Reset: hold reset_n=0 with m_psel=4'hF -> all outputs 0, no north activity.
//  2 Single write: m0 psel at t0, penable t1, pwdata=32'hA5A5_0001 -> north SETUP t1,
//    ACCESS+m_pready[0] t2. South shows 32'hA5A5_0001 at t2+16. pipeline_busy t3..t18.
//  3 All four request at once with data 32'h10..32'h13 -> grants 0,1,2,3. North ACCESS every
//    2nd cycle. South emits 10,11,12,13 in order. Each master gets one pready.
//  4 Fairness: m0 and m2 request continuously -> grants alternate 0,2,0,2. Neither gets
//    2 consecutive grants.
//  5 Late penable: granted m1 holds penable=0 for 3 cycles -> north psel=1/penable=0 during the
//    wait. Exactly one shift, and pready arrives on the penable cycle.
//  6 Reset in ACCESS wait: assert reset_n=0 -> no pready; next cycle outputs 0 and
//    pipeline_busy=0. After release m0 wins first.

Source files
------------

// File: rtl/apb_pipeline_pkg.sv
// Shared types and constants for the APB write pipeline and its north-side arbiter.
package apb_pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } arb_state_e;

  localparam int PIPE_LATENCY_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first unmasked requester after last_ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  int cand;

  // NOTE: every output gets a default before the search loop, so no path can leave a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_ptr) + i) % N;
      if (!valid && req[cand] && !mask[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_north_arbiter.sv
// Round-robin arbiter sharing the pipeline's north APB port among several write masters,
// with an in-flight tracker that reports when completed writes have yet to leave south.
module apb_north_arbiter
  import apb_pipeline_pkg::*;
#(
  parameter int NUM_MASTERS  = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            m_psel,
  input  logic [NUM_MASTERS-1:0]            m_penable,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata,
  output logic [NUM_MASTERS-1:0]            m_pready,
  output logic                              north_psel,
  output logic                              north_penable,
  output logic [DATA_WIDTH-1:0]             north_pwdata,
  output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
  output logic                              pipeline_busy
);

  localparam int IW = $clog2(NUM_MASTERS);

  arb_state_e              state;
  logic [IW-1:0]           grant_q;
  logic [IW-1:0]           last_ptr;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [PIPE_LATENCY-1:0] inflight;

  logic [NUM_MASTERS-1:0]  grant_onehot;
  logic [NUM_MASTERS-1:0]  excl;
  logic [NUM_MASTERS-1:0]  win_onehot;
  logic [IW-1:0]           win_idx;
  logic                    win_valid;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    complete;
  logic                    take;

  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_rr (
    .req       (m_psel),
    .mask      (excl),
    .last_ptr  (last_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  // The current owner is masked during ACCESS so it can only re-win from IDLE.
  // Completion is gated by reset_n so an aborted transfer never reaches the master or north.
  always_comb begin
    grant_onehot          = '0;
    grant_onehot[grant_q] = 1'b1;
    excl     = (state == ACCESS) ? grant_onehot : '0;
    complete = (state == ACCESS) && m_penable[grant_q] && reset_n;
    take     = ((state == IDLE) || complete) && win_valid;
    win_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_onehot[i]) win_data = m_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      last_ptr <= IW'(NUM_MASTERS - 1);
      data_q   <= '0;
      inflight <= '0;
    end else begin
      inflight <= {inflight[PIPE_LATENCY-2:0], complete};
      if (take) begin
        grant_q  <= win_idx;
        last_ptr <= win_idx;
        data_q   <= win_data;
      end
      case (state)
        IDLE:    if (take) state <= SETUP;
        SETUP:   state <= ACCESS;
        ACCESS:  if (complete) state <= take ? SETUP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign north_psel    = (state != IDLE);
  assign north_penable = complete;
  assign north_pwdata  = data_q;
  assign grant_id      = grant_q;
  assign m_pready      = complete ? grant_onehot : '0;
  assign pipeline_busy = |inflight;

endmodule

// File: tb/tb_apb_north_arbiter.sv
// Randomized masters against a transaction-level reference model of the north arbiter.
module tb_apb_north_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PL = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_psel;
  logic [N-1:0]    m_penable;
  logic [N*DW-1:0] m_pwdata;
  logic [N-1:0]    m_pready;
  logic            north_psel;
  logic            north_penable;
  logic [DW-1:0]   north_pwdata;
  logic [1:0]      grant_id;
  logic            pipeline_busy;

  always #5 clk = ~clk;

  apb_north_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .PIPE_LATENCY(PL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m_psel        (m_psel),
    .m_penable     (m_penable),
    .m_pwdata      (m_pwdata),
    .m_pready      (m_pready),
    .north_psel    (north_psel),
    .north_penable (north_penable),
    .north_pwdata  (north_pwdata),
    .grant_id      (grant_id),
    .pipeline_busy (pipeline_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the transaction currently owning north, plus completion history.
  bit            txn_active = 1'b0;
  int            txn_m      = 0;
  logic [DW-1:0] txn_data   = '0;
  int            txn_age    = 0;
  int            last_g     = N - 1;
  int            last_comp  = -1000;
  int            comps      = 0;
  bit            prev_rst   = 1'b0;
  bit            just_rst   = 1'b0;

  // Master agents.
  bit       served [N];
  logic [N-1:0] allow = '0;
  int       p_req    = 0;
  int       p_pen    = 0;
  bit       scramble = 1'b0;
  bit       clear_req = 1'b0;
  logic     rst_val  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    if (clear_req) begin
      m_psel    = '0;
      m_penable = '0;
      clear_req = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (served[i]) begin
        m_psel[i]    = 1'b0;
        m_penable[i] = 1'b0;
        served[i]    = 1'b0;
      end else if (!m_psel[i]) begin
        if (allow[i] && $urandom_range(99) < p_req) begin
          m_psel[i]              = 1'b1;
          m_pwdata[i*DW +: DW]   = $urandom;
        end
      end else begin
        if (!m_penable[i] && $urandom_range(99) < p_pen) m_penable[i] = 1'b1;
        if (scramble && $urandom_range(3) == 0) m_pwdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic model_cycle();
    logic [N-1:0] elig;
    logic [N-1:0] exp_ready;
    bit           done;
    bit           exp_pen;
    int           w;
    for (int i = 0; i < N; i++) if (m_pready[i]) served[i] = 1'b1;

    if (!reset_n) begin
      check("pready_in_reset", 64'(m_pready), 64'd0);
      if (prev_rst) begin
        check("rst_psel", 64'(north_psel), 64'd0);
        check("rst_penable", 64'(north_penable), 64'd0);
        check("rst_pwdata", 64'(north_pwdata), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(pipeline_busy), 64'd0);
      end
      txn_active = 1'b0;
      last_g     = N - 1;
      last_comp  = -1000;
      prev_rst   = 1'b1;
      just_rst   = 1'b1;
      return;
    end
    prev_rst = 1'b0;
    if (just_rst) begin
      check("post_rst_grant_id", 64'(grant_id), 64'd0);
      check("post_rst_pwdata", 64'(north_pwdata), 64'd0);
      just_rst = 1'b0;
    end

    // A completion at cycle k keeps busy high on cycles k+1 .. k+PL.
    check("busy", 64'(pipeline_busy), 64'((cyc - last_comp >= 1) && (cyc - last_comp <= PL)));

    done = 1'b0;
    if (txn_active) begin
      check("north_psel", 64'(north_psel), 64'd1);
      check("grant_id", 64'(grant_id), 64'(txn_m));
      check("north_pwdata", 64'(north_pwdata), 64'(txn_data));
      if (txn_age == 0) begin
        check("setup_penable", 64'(north_penable), 64'd0);
        check("setup_pready", 64'(m_pready), 64'd0);
      end else begin
        exp_pen   = m_penable[txn_m];
        exp_ready = '0;
        if (exp_pen) exp_ready[txn_m] = 1'b1;
        check("access_penable", 64'(north_penable), 64'(exp_pen));
        check("access_pready", 64'(m_pready), 64'(exp_ready));
        if (exp_pen) begin
          done      = 1'b1;
          last_comp = cyc;
          comps++;
        end
      end
    end else begin
      check("idle_psel", 64'(north_psel), 64'd0);
      check("idle_penable", 64'(north_penable), 64'd0);
      check("idle_pready", 64'(m_pready), 64'd0);
    end

    if (!txn_active || done) begin
      elig = m_psel;
      if (done) elig[txn_m] = 1'b0;
      txn_active = 1'b0;
      for (int k = 1; k <= N; k++) begin
        w = (last_g + k) % N;
        if (!txn_active && elig[w]) begin
          txn_active = 1'b1;
          txn_m      = w;
          txn_data   = m_pwdata[w*DW +: DW];
          txn_age    = 0;
        end
      end
      if (txn_active) last_g = txn_m;
    end else begin
      txn_age++;
    end
  endtask

  task automatic run(input int n, input logic rst);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      reset_n = rst;
      drive();
      @(negedge clk);
      model_cycle();
      cyc++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    m_psel    = '1;
    m_penable = '0;
    m_pwdata  = '0;
    for (int i = 0; i < N; i++) served[i] = 1'b0;

    // Reset held with every master requesting.
    run(4, 1'b0);
    clear_req = 1'b1;
    run(1, 1'b0);

    // Single master, then all four, then two competing masters.
    allow = 4'b0001; p_req = 100; p_pen = 100;
    run(16, 1'b1);
    allow = 4'b1111;
    run(40, 1'b1);
    allow = 4'b0101;
    run(40, 1'b1);

    // Random traffic with late penable and data changing after grant.
    allow = 4'b1111; p_req = 60; p_pen = 25; scramble = 1'b1;
    run(300, 1'b1);

    // Stall a granted master in its ACCESS wait, then reset in the middle of it.
    p_req = 100; p_pen = 0; scramble = 1'b0;
    run(20, 1'b1);
    run(2, 1'b0);
    p_pen = 100;
    run(60, 1'b1);

    // Drain and let pipeline_busy fall.
    allow = '0;
    run(40, 1'b1);

    check("progress", 64'(comps >= 20), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
